ram_sync_be: RTL and testbench

Parametrised single-port synchronous data RAM for the processor datapath. It replaces the tri-state shared data bus with separate write/read paths and a valid/ready request port. It adds per-byte write enables, a configurable read pipeline and out-of-range address detection. A hardware zero-fill engine clears memory after reset or on command, so software never reads uninitialised words.

---
 rtl/ram_sync_be_pkg.sv | 21 ++
 rtl/ram_array_be.sv | 30 +++
 rtl/ram_sync_be.sv | 156 +++++++++++++++
 tb/tb_ram_sync_be.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sync_be_pkg.sv
// Shared types and helpers for the byte-enabled synchronous data RAM.
// The address-bound helper keeps the range check at full request width.
package ram_sync_be_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Highest legal word address, saturated to what an addr_w-bit request can express.
  function automatic logic [63:0] max_addr(input int depth, input int addr_w);
    logic [63:0] lim;
    lim = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
    if (64'(depth - 1) < lim) return 64'(depth - 1);
    return lim;
  endfunction

endpackage

// File: rtl/ram_array_be.sv
// Plain byte-enabled synchronous array: one write port, registered read.
// A read of the word being written returns the old contents.
module ram_array_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/ram_sync_be.sv
// Single-port data RAM with valid/ready requests, byte enables, range check,
// hardware zero-fill and a 1- or 2-cycle response pipeline.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_FILL | writing zero to word[ptr]; requests are refused
//   ST_IDLE | serving requests; clear pulse restarts the fill
module ram_sync_be
  import ram_sync_be_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(max_addr(DEPTH, ADDR_W));
  localparam logic [AW-1:0]     LP_LAST     = AW'(DEPTH - 1);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("ram_sync_be: DATA_W must be a multiple of 8");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("ram_sync_be: READ_LAT must be 1 or 2");
  end
  if (ADDR_W < AW) begin : g_bad_addr_w
    $error("ram_sync_be: ADDR_W too narrow for DEPTH");
  end

  state_e               r_state, w_state_nxt;
  logic [AW-1:0]        r_ptr, w_ptr_nxt;
  logic                 w_fill, w_accept, w_in_range;
  logic                 w_arr_we;
  logic [AW-1:0]        w_arr_addr;
  logic [DATA_W-1:0]    w_arr_wdata, w_arr_rdata, w_rdata1;
  logic [DATA_W/8-1:0]  w_arr_be;
  logic                 r_v1, r_err1, r_rd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_FILL: begin
        if (clear) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          w_state_nxt = ST_FILL;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign w_fill     = (r_state == ST_FILL);
  assign busy       = w_fill;
  assign req_ready  = (r_state == ST_IDLE) && !clear;
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = (req_addr <= LP_MAX_ADDR);

  // Out-of-range requests steer the array to word 0 so it never indexes past DEPTH.
  assign w_arr_we    = w_fill || (w_accept && req_we && w_in_range);
  assign w_arr_addr  = w_fill ? r_ptr : (w_in_range ? req_addr[AW-1:0] : '0);
  assign w_arr_wdata = w_fill ? '0 : req_wdata;
  assign w_arr_be    = w_fill ? '1 : req_be;

  ram_array_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .addr  (w_arr_addr),
    .wdata (w_arr_wdata),
    .be    (w_arr_be),
    .rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_err1 <= 1'b0;
      r_rd1  <= 1'b0;
    end else begin
      r_v1   <= w_accept;
      r_err1 <= w_accept && !w_in_range;
      r_rd1  <= w_accept && !req_we && w_in_range;
    end
  end

  // Array output is only meaningful for in-range reads; everything else returns zero.
  assign w_rdata1 = r_rd1 ? w_arr_rdata : '0;

  if (READ_LAT == 2) begin : g_lat2
    logic              r_v2, r_err2;
    logic [DATA_W-1:0] r_rdata2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v2     <= 1'b0;
        r_err2   <= 1'b0;
        r_rdata2 <= '0;
      end else begin
        r_v2     <= r_v1;
        r_err2   <= r_err1;
        r_rdata2 <= w_rdata1;
      end
    end

    assign rsp_valid = r_v2;
    assign rsp_err   = r_err2;
    assign rsp_rdata = r_rdata2;
  end else begin : g_lat1
    assign rsp_valid = r_v1;
    assign rsp_err   = r_err1;
    assign rsp_rdata = w_rdata1;
  end

endmodule

// File: tb/tb_ram_sync_be.sv
// Directed bench for ram_sync_be: two instances (DEPTH 32 / latency 2 and
// DEPTH 20 / latency 1) share one request stream; responses are scoreboarded.
module tb_ram_sync_be;
  import ram_sync_be_pkg::*;

  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int DEPTH_A = 32;
  localparam int LAT_A   = 2;
  localparam int DEPTH_B = 20;
  localparam int LAT_B   = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic [BE_W-1:0] req_be = '0;

  logic          a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [DW-1:0] b_rsp_rdata;

  ram_sync_be #(.DATA_W(DW), .DEPTH(DEPTH_A), .ADDR_W(AW), .READ_LAT(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  ram_sync_be #(.DATA_W(DW), .DEPTH(DEPTH_B), .ADDR_W(AW), .READ_LAT(LAT_B)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_a;
    logic        err_a;
    logic [31:0] exp_b;
    logic        err_b;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b, p_a, p_b;
  vec_t        vt[$];
  logic [31:0] cur_exp_a = '0, cur_exp_b = '0;
  logic        cur_err_a = 1'b0, cur_err_b = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q_a.delete();
    end else begin
      if (a_rsp_valid) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_rsp", 32'(a_rsp_valid), 32'd0);
        end else begin
          e_a = q_a.pop_front();
          check("a_rsp_cycle", 32'(cyc), 32'(e_a.due));
          check("a_rsp_rdata", a_rsp_rdata, e_a.data);
          check("a_rsp_err", 32'(a_rsp_err), 32'(e_a.err));
        end
      end
      while (q_a.size() > 0 && q_a[0].due < cyc) begin
        check("a_missing_rsp", 32'd0, 32'd1);
        void'(q_a.pop_front());
      end
      if (req_valid && a_req_ready) begin
        p_a.due = cyc + LAT_A; p_a.data = cur_exp_a; p_a.err = cur_err_a;
        q_a.push_back(p_a);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q_b.delete();
    end else begin
      if (b_rsp_valid) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
        end else begin
          e_b = q_b.pop_front();
          check("b_rsp_cycle", 32'(cyc), 32'(e_b.due));
          check("b_rsp_rdata", b_rsp_rdata, e_b.data);
          check("b_rsp_err", 32'(b_rsp_err), 32'(e_b.err));
        end
      end
      while (q_b.size() > 0 && q_b[0].due < cyc) begin
        check("b_missing_rsp", 32'd0, 32'd1);
        void'(q_b.pop_front());
      end
      if (req_valid && b_req_ready) begin
        p_b.due = cyc + LAT_B; p_b.data = cur_exp_b; p_b.err = cur_err_b;
        q_b.push_back(p_b);
      end
    end
  end

  task automatic issue(input vec_t v);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    cur_exp_a = v.exp_a; cur_err_a = v.err_a;
    cur_exp_b = v.exp_b; cur_err_b = v.err_b;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic read_all();
    vec_t v;
    for (int a = 0; a < DEPTH_A; a++) begin
      v = '{1'b0, 16'(a), 32'h0, 4'hF, 32'h0, 1'b0, 32'h0, (a >= DEPTH_B)};
      issue(v);
    end
    idle();
  endtask

  task automatic wait_ready(input int lim);
    int k;
    k = 0;
    while (!(a_req_ready && b_req_ready) && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("wait_ready", 32'(a_req_ready && b_req_ready), 32'd1);
  endtask

  task automatic count_busy(input int win, output int na, output int nb);
    na = 0; nb = 0;
    for (int k = 0; k < win; k++) begin
      @(negedge clk);
      if (a_busy) na++;
      if (b_busy) nb++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    int   na, nb;
    vec_t v;

    // we, addr, wdata, be, exp_a, err_a, exp_b, err_b
    vt.push_back('{1'b1, 16'd5,      32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b1, 16'd5,      32'h11223344, 4'h5, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 16'd5,      32'h0,        4'hF, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0});
    vt.push_back('{1'b1, 16'd1,      32'h1,        4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b1, 16'd2,      32'h2,        4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b1, 16'd3,      32'h3,        4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 16'd1,      32'h0,        4'hF, 32'h1,        1'b0, 32'h1,        1'b0});
    vt.push_back('{1'b0, 16'd2,      32'h0,        4'hF, 32'h2,        1'b0, 32'h2,        1'b0});
    vt.push_back('{1'b0, 16'd3,      32'h0,        4'hF, 32'h3,        1'b0, 32'h3,        1'b0});
    vt.push_back('{1'b1, 16'd4,      32'h44,       4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b1, 16'd20,     32'hDEAD,     4'hF, 32'h0,        1'b0, 32'h0,        1'b1});
    vt.push_back('{1'b0, 16'h8014,   32'h0,        4'hF, 32'h0,        1'b1, 32'h0,        1'b1});
    vt.push_back('{1'b0, 16'd20,     32'h0,        4'hF, 32'h0000DEAD, 1'b0, 32'h0,        1'b1});
    vt.push_back('{1'b1, 16'h0024,   32'hBAD,      4'hF, 32'h0,        1'b1, 32'h0,        1'b1});
    vt.push_back('{1'b0, 16'd4,      32'h0,        4'hF, 32'h44,       1'b0, 32'h44,       1'b0});
    vt.push_back('{1'b1, 16'd9,      32'h7,        4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 16'd9,      32'h0,        4'hF, 32'h7,        1'b0, 32'h7,        1'b0});
    vt.push_back('{1'b1, 16'd9,      32'h8,        4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 16'd9,      32'h0,        4'hF, 32'h8,        1'b0, 32'h8,        1'b0});
    vt.push_back('{1'b1, 16'd6,      32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 16'd6,      32'h0,        4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b1, 16'd7,      32'h12345678, 4'h8, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1'b0, 16'd7,      32'h0,        4'hF, 32'h12000000, 1'b0, 32'h12000000, 1'b0});
    vt.push_back('{1'b0, 16'd31,     32'h0,        4'hF, 32'h0,        1'b0, 32'h0,        1'b1});
    vt.push_back('{1'b0, 16'hFFFF,   32'h0,        4'hF, 32'h0,        1'b1, 32'h0,        1'b1});
    vt.push_back('{1'b0, 16'd5,      32'h0,        4'h0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0});

    repeat (3) @(negedge clk);
    check("rst_a_ready", 32'(a_req_ready), 32'd0);
    check("rst_a_busy",  32'(a_busy),      32'd1);
    check("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_rdata", a_rsp_rdata,      32'd0);
    check("rst_a_err",   32'(a_rsp_err),   32'd0);
    check("rst_b_ready", 32'(b_req_ready), 32'd0);
    check("rst_b_busy",  32'(b_busy),      32'd1);
    check("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    check("rst_b_rdata", b_rsp_rdata,      32'd0);
    check("rst_b_err",   32'(b_rsp_err),   32'd0);

    // Reset again once the fill pointer has reached 10; the fill must restart.
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midfill_rst_busy",  32'(a_busy),      32'd1);
    check("midfill_rst_valid", 32'(a_rsp_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    count_busy(50, na, nb);
    check("fill_cycles_a", 32'(na), 32'd32);
    check("fill_cycles_b", 32'(nb), 32'd20);
    check("ready_after_fill_a", 32'(a_req_ready), 32'd1);
    check("ready_after_fill_b", 32'(b_req_ready), 32'd1);

    read_all();
    foreach (vt[i]) issue(vt[i]);
    idle();

    // Clear with responses still in flight; the refused request must not respond.
    wait_ready(10);
    for (int a = 1; a <= 3; a++) begin
      v = '{1'b0, 16'(a), 32'h0, 4'hF, 32'(a), 1'b0, 32'(a), 1'b0};
      issue(v);
    end
    @(posedge clk); #1;
    clear = 1'b1;
    req_addr = 16'd4;
    @(negedge clk);
    check("clear_gates_ready_a", 32'(a_req_ready), 32'd0);
    check("clear_gates_ready_b", 32'(b_req_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    req_valid = 1'b0;
    count_busy(50, na, nb);
    check("clear_fill_cycles_a", 32'(na), 32'd32);
    check("clear_fill_cycles_b", 32'(nb), 32'd20);
    wait_ready(10);
    read_all();

    // Reset with a read in flight drops its response.
    wait_ready(10);
    v = '{1'b0, 16'd5, 32'h0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0};
    issue(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("inflight_rst_valid_a", 32'(a_rsp_valid), 32'd0);
    check("inflight_rst_valid_b", 32'(b_rsp_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    count_busy(40, na, nb);
    check("refill_cycles_a", 32'(na), 32'd32);

    repeat (5) @(negedge clk);
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
